fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage: owns the PC, drives the word address of the synchronous instruction ROM,
//   and hands (pc, instruction) pairs to the decoder over a valid/ready handshake.
//   Absorbs the ROM's 1-cycle read latency with an in-flight tracker and a small output FIFO.
//   Accepts branch/jump redirects from execute, which kill in-flight and buffered fetches.
// PARAMETERS
//   ADDR_W     5        ROM word-address width; imem_addr = pc[ADDR_W+1:2]
//   RESET_PC   32'h0    PC loaded on reset (bits [1:0] must be 0)
//   FIFO_DEPTH 2        output buffer entries, >= 2
// PORTS
//   clk             in   1       clock, all state updates on posedge
//   rst_n           in   1       synchronous active-low reset
//   fetch_en        in   1       1 = new fetches may be issued
//   redirect_valid  in   1       load redirect_pc this cycle, flush pipeline
//   redirect_pc     in   32      redirect target (byte address)
//   imem_addr       out  ADDR_W  ROM word address, combinational from pc_q
//   imem_instr      in   32      ROM data, valid the cycle after the address is sampled
//   if_valid        out  1       FIFO head valid
//   if_ready        in   1       decoder accepts head
//   if_pc           out  32      PC of head instruction
//   if_instr        out  32      head instruction
// BEHAVIOUR
//   Reset (rst_n low at an edge): pc_q<=RESET_PC, inflight<=0, FIFO emptied; if_valid=0,
//     if_pc=0, if_instr=0 after that edge; imem_addr tracks pc_q.
//   pop   = if_valid & if_ready & !redirect_valid.
//   avail = FIFO_DEPTH - count - inflight + pop (unsigned, no underflow by construction).
//   issue = fetch_en & !redirect_valid & (avail > 0). On issue edge: ROM samples imem_addr,
//     inflight<=1, inflight_pc<=pc_q, pc_q<=pc_q+4. Else inflight<=0.
//   Return: inflight=1 at an edge -> push {inflight_pc, imem_instr} to FIFO tail.
//   Latency: the first if_valid rises after the 2nd edge following issue; steady-state throughput
//     is 1 instr/cycle with if_ready=1.
//   Backpressure: if_ready=0 -> head and pc_q hold once avail=0; no instruction is lost or duplicated.
//   Push and pop on the same edge are both honoured; count unchanged.
//   Redirect (priority over everything): pc_q<={redirect_pc[31:2],2'b00}, inflight<=0, FIFO
//     flushed, no issue, no pop that edge (a handshake in that cycle is void). Target is issued
//     on the next edge; its if_valid rises 2 edges later. Low PC bits are silently cleared.
//   fetch_en=0: no issue; an in-flight fetch still returns and is buffered; the FIFO drains normally.
//   PC arithmetic: 32-bit, wraps at 2^32. imem_addr aliases modulo 2^ADDR_W words
//     (pc 0x80 -> index 0 when ADDR_W=5).
//   Reset mid-operation: same as reset; the ROM data returning after reset is discarded (inflight=0).
//   Outputs if_pc/if_instr come from registered FIFO storage; imem_addr is the only comb output.
// TESTING  (ROM model: 32 words, word i = i+1; if_ready=1 unless stated)
//   Release reset, fetch_en=1 -> if_valid rises 2 edges later; stream pc 0,4,8,... with
//     instr 1,2,3,... one per cycle, no gaps.
//   if_ready=0 for 5 cycles while head pc=8 -> head holds 8/3, imem_addr freezes after FIFO fills;
//     on release: 12/4, 16/5 with no loss or repeat.
//   redirect 0x40 while FIFO full and if_ready=1 -> nothing accepted that cycle; next if_valid
//     2 edges later shows pc 0x40 / instr 17; no stale pc 12 appears.
//   redirect 0x46 -> pc 0x44 / instr 18.
//   Run to pc 0x7C (instr 32) -> next pc 0x80, imem_addr 0, instr 1.
//   fetch_en=0 for 4 cycles -> buffered entries drain, if_valid falls, resume in order.
//   rst_n low 1 cycle mid-stream -> if_valid 0 after that edge; restart at RESET_PC / instr 1.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues ROM reads, and buffers (pc, instr)
// pairs in a small FIFO toward the decoder; redirects flush everything in flight.
module fetch_unit #(
  parameter int          ADDR_W     = 5,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AV_W  = CNT_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        pc_q, inflight_pc;
  logic               inflight;
  logic               pop, push, issue;
  logic [AV_W-1:0]    avail;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign imem_addr = pc_q[ADDR_W+1:2];
  assign if_valid  = (count != '0);
  assign if_pc     = mem[rd_ptr].pc;
  assign if_instr  = mem[rd_ptr].instr;

  // Free slots counted against the in-flight read, so a returning word always has room.
  always_comb begin
    pop   = if_valid & if_ready & ~redirect_valid;
    push  = inflight;
    avail = AV_W'(FIFO_DEPTH) - AV_W'(count) - AV_W'(inflight) + AV_W'(pop);
    issue = fetch_en & ~redirect_valid & (avail != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + 32'd4;
      end
      if (push) begin
        mem[wr_ptr] <= '{pc: inflight_pc, instr: imem_instr};
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, with the decoder-side
// stream checked against a sequential-PC model (reset/redirect restart, +4 per accept).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, fetch_en, redirect_valid, if_ready, if_valid;
  logic [31:0] redirect_pc, imem_instr, if_pc, if_instr;
  logic [4:0]  imem_addr;

  int          checks = 0, errors = 0, hs = 0;
  logic [31:0] exp_pc = 32'h0;

  always #5 clk = ~clk;

  // Synchronous ROM: word i holds i+1
  always @(posedge clk) imem_instr <= 32'(imem_addr) + 32'd1;

  fetch_unit #(.ADDR_W(5), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  function automatic logic [31:0] rom_of(input logic [31:0] pc);
    return ((pc >> 2) % 32) + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every accepted instruction must be the next one in program order.
  task automatic tick();
    if (!rst_n) exp_pc = 32'h0;
    else if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    else if (if_valid === 1'b1 && if_ready) begin
      chk("stream_pc", if_pc, exp_pc);
      chk("stream_instr", if_instr, rom_of(exp_pc));
      exp_pc += 32'd4;
      hs++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n = 0;
    while (if_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(if_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Start-up latency and gap-free stream
    rst_n = 1'b1; fetch_en = 1'b1;
    tick();
    chk("lat_edge1", 32'(if_valid), 32'd0);
    tick();
    chk("lat_edge2", 32'(if_valid), 32'd1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_instr", if_instr, 32'd1);
    tick(); chk("nogap1", 32'(if_valid), 32'd1);
    tick(); chk("nogap2", 32'(if_valid), 32'd1);
    chk("head8", if_pc, 32'h8);

    // Backpressure: head holds, PC freezes two words ahead of head
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_pc", if_pc, 32'h8);
      chk("bp_instr", if_instr, 32'd3);
      chk("bp_addr", 32'(imem_addr), 32'd4);
    end
    if_ready = 1'b1;
    tick(); chk("rel_pc1", if_pc, 32'hC); chk("rel_instr1", if_instr, 32'd4);
    tick(); chk("rel_pc2", if_pc, 32'h10); chk("rel_instr2", if_instr, 32'd5);

    // Redirect while the FIFO is full and the decoder is ready
    if_ready = 1'b0;
    tick(); tick(); tick();
    chk("full_head", if_pc, 32'h10);
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush", 32'(if_valid), 32'd0);
    tick(); chk("redir_issue", 32'(if_valid), 32'd0);
    tick();
    chk("redir_valid", 32'(if_valid), 32'd1);
    chk("redir_pc", if_pc, 32'h40);
    chk("redir_instr", if_instr, 32'd17);

    // Misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h46;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    chk("mis_pc", if_pc, 32'h44);
    chk("mis_instr", if_instr, 32'd18);

    // Address aliasing past the ROM end
    for (int n = 0; n < 40 && !(if_valid === 1'b1 && if_pc == 32'h78); n++) tick();
    chk("wrap_reach", if_pc, 32'h78);
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    tick(); tick();
    chk("wrap_pc", if_pc, 32'h80);
    chk("wrap_instr", if_instr, 32'd1);

    // fetch_en low: drain then resume in order
    fetch_en = 1'b0;
    tick(); tick();
    chk("fen_drain", 32'(if_valid), 32'd0);
    tick(); tick();
    chk("fen_idle", 32'(if_valid), 32'd0);
    chk("fen_addr", 32'(imem_addr), 32'd2);
    fetch_en = 1'b1;
    wait_valid(4, "fen_resume");
    chk("fen_pc", if_pc, 32'h88);
    chk("fen_instr", if_instr, rom_of(32'h88));

    // Reset mid-stream
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", 32'(if_valid), 32'd0);
    chk("mrst_pc", if_pc, 32'h0);
    chk("mrst_instr", if_instr, 32'h0);
    tick(); chk("mrst_lat", 32'(if_valid), 32'd0);
    tick();
    chk("mrst_valid2", 32'(if_valid), 32'd1);
    chk("mrst_pc2", if_pc, 32'h0);
    chk("mrst_instr2", if_instr, 32'd1);

    // Random traffic against the sequential model
    hs = 0;
    for (int i = 0; i < 800; i++) begin
      if_ready       = ($urandom_range(0, 9) < 7);
      fetch_en       = ($urandom_range(0, 9) < 8);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      rst_n          = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1; redirect_valid = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
    wait_valid(6, "rand_recover");
    chk("rand_progress", 32'(hs > 150), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
